param_cache: RTL and testbench
==============================

# param_cache

Parametrised, direct-mapped, write-through / no-write-allocate cache between the CPU core and the memory bus. It replaces the fixed 16-bit-address, 8-bit-data cache with configurable address, data and index widths. It adds a registered request/ready handshake on the CPU side, a request/acknowledge handshake on the memory side, a whole-cache flush, and saturating hit/miss counters for performance monitoring.

## Interface

Parameters:

- ADDR_W, 16, address width
- DATA_W, 8, data word width
- INDEX_W, 4, index bits; 2^INDEX_W lines of one word each; tag = ADDR_W-INDEX_W bits
- CNT_W, 16, width of hit/miss counters

Ports:

- clk_1  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  request; sampled only in IDLE
- cpu_we  in  1  1 = write, 0 = read; latched with request
- cpu_addr  in  ADDR_W  request address; latched with request
- cpu_wdata  in  DATA_W  write data; latched with request
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data, valid while cpu_ready=1
- cpu_hit  out  1  lookup result of the completing request, valid while cpu_ready=1
- flush  in  1  invalidate all lines
- mem_req  out  1  memory access request
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, sampled on clk_1
- hit_count  out  CNT_W  saturating hit counter
- miss_count  out  CNT_W  saturating miss counter

## Operation

- Address split: index = addr[INDEX_W-1:0]; tag = addr[ADDR_W-1:INDEX_W]. Hit means the line is valid and the stored tag equals the request tag.
- FSM states are IDLE, FILL, WRITE and DONE.
- IDLE:
  - If flush=1: clear all valid bits and stay in IDLE. flush has priority over cpu_req, which is left pending.
  - Otherwise, if cpu_req=1: latch we, addr and wdata.
    - Read hit: go to DONE.
    - Read miss: go to FILL.
    - Write (hit or miss): go to WRITE.
- FILL: mem_req=1, mem_we=0, mem_addr=latched addr. On an edge with mem_ack=1: write mem_rdata and the tag into the line, set valid, drive cpu_rdata=mem_rdata, go to DONE.
- WRITE: mem_req=1, mem_we=1, mem_addr and mem_wdata come from the latch.
  - On mem_ack, if the write hit, update the line data.
  - A write miss leaves the line untouched (no allocate).
  - Then go to DONE.
- DONE: cpu_ready=1 for exactly one cycle, then IDLE. cpu_req is ignored in DONE, FILL and WRITE.
- Counters update at the lookup edge in IDLE, writes included:
  - hit: hit_count+1
  - miss: miss_count+1
  - Both saturate at 2^CNT_W-1.
  - flush does not clear the counters.
- flush asserted in FILL/WRITE/DONE is not latched. The requester holds flush until it is accepted in IDLE.

## Timing

- Reset values:
  - Outputs: cpu_ready=0, cpu_rdata=0, cpu_hit=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, hit_count=0, miss_count=0.
  - Internal: all valid bits 0, state IDLE. Tag and data arrays are not reset.
- Reset mid-operation: state returns to IDLE immediately (asynchronously) and mem_req drops in the same cycle. Any in-flight line update is discarded.
- Read hit: request accepted at edge N; cpu_ready=1 in the cycle after edge N. Hit throughput is one request per 2 cycles.
- Miss or write: mem_req rises the cycle after acceptance. If mem_ack is sampled at edge M, cpu_ready=1 in the cycle after M and mem_req=0 in that same cycle.
- mem_req, mem_we, mem_addr and mem_wdata are decoded from state and latched registers: glitch-free and stable while mem_req=1.
- Refill data can be hit by the next request: a new request accepted in the IDLE cycle following DONE observes it.

## Structure

- Package cache_pkg holds the FSM state encoding (IDLE, FILL, WRITE, DONE as 2-bit localparams) and the counter-saturation helper function.
- Sub-module cache_line_store holds:
  - the valid, tag and data arrays
  - asynchronous clear of valid on rst, synchronous clear on flush
  - combinational lookup (hit, rdata)
  - a synchronous line write port
- The top level holds the FSM, the request latch, the handshake outputs and the counters.

## Test plan

All scenarios use ADDR_W=16, DATA_W=8, INDEX_W=4.

1. Reset, then read 0x0010 with mem_ack two cycles after mem_req and mem_rdata=0x10 -> mem_req=1, mem_we=0, mem_addr=0x0010; cpu_ready pulse with cpu_rdata=0x10, cpu_hit=0; miss_count=1.
2. Re-read 0x0010 -> cpu_ready the cycle after acceptance, mem_req never asserted, cpu_rdata=0x10, cpu_hit=1, hit_count=1.
3. Conflict: read 0x0110 (index 0), fill 0x22; then read 0x0010 -> miss with mem_addr=0x0010. Read 0x0110 again -> hit returns 0x22... only if not evicted; after the 0x0010 refill it must miss.
4. Write 0xA5 to cached 0x0010 -> mem_we=1, mem_wdata=0xA5; a later read hits and returns 0xA5. Write to uncached 0x0005 -> after ack, a read of 0x0005 misses (no allocate).
5. flush and cpu_req (read 0x0010) high in the same IDLE cycle -> flush accepted first, then the request misses. Reset asserted during FILL -> mem_req falls with rst and the next read of the same address misses.
6. CNT_W=2, five consecutive hits -> hit_count saturates at 3 and stays there.

Source files
------------

// File: rtl/param_cache_pkg.sv
// cache_pkg: shared definitions for param_cache.
//   - FSM state encoding (2-bit) and its enum view
//   - sat_inc: saturating increment used by the hit/miss counters
package cache_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    FILL  = ST_FILL,
    WRITE = ST_WRITE,
    DONE  = ST_DONE
  } state_t;

  // Increment v, clamped to 2^w-1. Carried at 64 bits so one helper serves
  // any counter width; callers cast to their own width.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] max;
    max = (64'd1 << w) - 64'd1;
    return (v >= max) ? max : v + 64'd1;
  endfunction

endpackage

// File: rtl/param_cache_if.sv
// param_cache_if: CPU-side and memory-side handshake signals of param_cache.
//   slave  : the cache's view (CPU request in, memory request out)
//   master : the environment's view (CPU + memory)
//   cpu_req/cpu_we/cpu_addr/cpu_wdata, flush   -> cache
//   cpu_ready/cpu_rdata/cpu_hit                 <- cache
//   mem_req/mem_we/mem_addr/mem_wdata           <- cache
//   mem_rdata/mem_ack                           -> cache
interface param_cache_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_hit;
  logic              flush;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata, mem_ack,
    output cpu_ready, cpu_rdata, cpu_hit, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata, mem_ack,
    input  cpu_ready, cpu_rdata, cpu_hit, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/param_cache_line_store.sv
// cache_line_store: valid/tag/data arrays of a direct-mapped cache.
//   clk, rst   : clock, async active-high reset (clears valid only)
//   clear      : synchronous invalidate of every line
//   lk_addr    : lookup address -> lk_hit, lk_rdata (combinational)
//   wr_en/wr_addr/wr_data : synchronous line write (tag from wr_addr, sets valid)
module cache_line_store #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int INDEX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [ADDR_W-1:0] lk_addr,
  output logic              lk_hit,
  output logic [DATA_W-1:0] lk_rdata,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);
  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W;

  logic [LINES-1:0]             valid;
  logic [LINES-1:0][TAG_W-1:0]  tags;
  logic [LINES-1:0][DATA_W-1:0] data;

  logic [INDEX_W-1:0] lk_idx, wr_idx;
  logic [TAG_W-1:0]   lk_tag, wr_tag;

  assign lk_idx   = lk_addr[INDEX_W-1:0];
  assign lk_tag   = lk_addr[ADDR_W-1:INDEX_W];
  assign wr_idx   = wr_addr[INDEX_W-1:0];
  assign wr_tag   = wr_addr[ADDR_W-1:INDEX_W];
  assign lk_hit   = valid[lk_idx] && (tags[lk_idx] == lk_tag);
  assign lk_rdata = data[lk_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        valid         <= '0;
    else if (clear) valid         <= '0;
    else if (wr_en) valid[wr_idx] <= 1'b1;
  end

  // Tag/data carry no reset; valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
  end
endmodule

// File: rtl/param_cache.sv
// param_cache: direct-mapped, write-through, no-write-allocate cache.
//   clk_1, rst           : clock, async active-high reset
//   bus (slave modport)  : CPU request/ready and memory request/ack handshakes
//   hit_count/miss_count : saturating lookup counters (not cleared by flush)
module param_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int INDEX_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk_1,
  input  logic             rst,
  param_cache_if.slave     bus,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);
  state_t            state, state_nx;
  logic              we_q, hit_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              lk_hit;
  logic [DATA_W-1:0] lk_rdata;
  logic              flush_go, accept, wr_en;
  logic [DATA_W-1:0] wr_data;

  // flush wins over a simultaneous request; the request stays pending.
  assign flush_go = (state == IDLE) && bus.flush;
  assign accept   = (state == IDLE) && !bus.flush && bus.cpu_req;
  // Fills always write the line; writes only update a line they hit.
  assign wr_en    = bus.mem_ack && ((state == FILL) || ((state == WRITE) && hit_q));
  assign wr_data  = (state == FILL) ? bus.mem_rdata : wdata_q;

  cache_line_store #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INDEX_W(INDEX_W)) u_store (
    .clk      (clk_1),
    .rst      (rst),
    .clear    (flush_go),
    .lk_addr  (bus.cpu_addr),
    .lk_hit   (lk_hit),
    .lk_rdata (lk_rdata),
    .wr_en    (wr_en),
    .wr_addr  (addr_q),
    .wr_data  (wr_data)
  );

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.cpu_ready = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.cpu_we)  state_nx = WRITE;
          else if (lk_hit) state_nx = DONE;
          else             state_nx = FILL;
        end
      end
      FILL: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) state_nx = DONE;
      end
      WRITE: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        if (bus.mem_ack) state_nx = DONE;
      end
      DONE: begin
        bus.cpu_ready = 1'b1;
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Address/data come straight from the latch so they hold steady under mem_req.
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_rdata = rdata_q;
  assign bus.cpu_hit   = hit_q;

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      we_q       <= 1'b0;
      hit_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (accept) begin
        we_q    <= bus.cpu_we;
        hit_q   <= lk_hit;
        addr_q  <= bus.cpu_addr;
        wdata_q <= bus.cpu_wdata;
        if (!bus.cpu_we && lk_hit) rdata_q <= lk_rdata;
        if (lk_hit) hit_count  <= CNT_W'(sat_inc(64'(hit_count), CNT_W));
        else        miss_count <= CNT_W'(sat_inc(64'(miss_count), CNT_W));
      end
      if ((state == FILL) && bus.mem_ack) rdata_q <= bus.mem_rdata;
    end
  end

  logic unused_we;
  assign unused_we = we_q;
endmodule

// File: tb/tb_param_cache.sv
// Scoreboard bench for param_cache (ADDR_W=16, DATA_W=8, INDEX_W=4, CNT_W=2).
// Stimulus pushes expected CPU responses and memory transactions; a monitor
// pops CPU responses on cpu_ready, and the memory responder pops and checks
// each memory transaction as it starts, acking two cycles after mem_req.
module tb_param_cache;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int IW = 4;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [CW-1:0] hit_count, miss_count;

  param_cache_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  param_cache #(.ADDR_W(AW), .DATA_W(DW), .INDEX_W(IW), .CNT_W(CW)) dut (
    .clk_1      (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  typedef struct {
    logic          hit;
    logic [DW-1:0] rdata;
    bit            chk_rd;
  } cpu_exp_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_exp_t;

  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];
  logic [DW-1:0] mem [int];
  int compared   = 0;
  int mismatched = 0;
  int exp_hc = 0;
  int exp_mc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // CPU response monitor
  always @(negedge clk) begin
    cpu_exp_t e;
    if (!rst && bus.cpu_ready === 1'b1) begin
      if (cpu_q.size() == 0) chk("unexpected cpu_ready", 32'd1, 32'd0);
      else begin
        e = cpu_q.pop_front();
        chk("cpu_hit", 32'(bus.cpu_hit), 32'(e.hit));
        if (e.chk_rd) chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(e.rdata));
      end
    end
  end

  // Memory responder: ack two cycles after mem_req rises
  bit active = 0;
  int cnt = 0;
  always @(negedge clk) begin
    mem_exp_t m;
    if (rst) begin
      active = 0; cnt = 0;
      bus.mem_ack = 1'b0;
      bus.mem_rdata = '0;
    end else if (bus.mem_ack) begin
      bus.mem_ack = 1'b0;
      active = 0;
    end else if (bus.mem_req) begin
      if (!active) begin
        active = 1; cnt = 0;
        if (mem_q.size() == 0) chk("unexpected mem_req", 32'd1, 32'd0);
        else begin
          m = mem_q.pop_front();
          chk("mem_we", 32'(bus.mem_we), 32'(m.we));
          chk("mem_addr", 32'(bus.mem_addr), 32'(m.addr));
          if (m.we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(m.wdata));
        end
      end
      cnt++;
      if (cnt == 2) begin
        bus.mem_ack = 1'b1;
        if (bus.mem_we) mem[int'(bus.mem_addr)] = bus.mem_wdata;
        else bus.mem_rdata = mem.exists(int'(bus.mem_addr)) ? mem[int'(bus.mem_addr)] : '0;
      end
    end
  end

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // One request from IDLE to completion; entered and left at a negedge in IDLE.
  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic exp_hit, input logic [DW-1:0] exp_rd, input bit with_flush);
    int lat;
    bit mem_access;
    mem_exp_t m;
    cpu_exp_t c;
    mem_access = we || !exp_hit;
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
    if (with_flush) begin
      bus.flush = 1'b1;
      @(posedge clk); #1;
      chk("flush cycle mem_req", 32'(bus.mem_req), 32'd0);
      @(negedge clk);
      bus.flush = 1'b0;
    end
    c.hit = exp_hit; c.rdata = exp_rd; c.chk_rd = !we;
    cpu_q.push_back(c);
    if (mem_access) begin
      m.we = we; m.addr = addr; m.wdata = wd;
      mem_q.push_back(m);
    end
    @(posedge clk);
    if (exp_hit) exp_hc = sat(exp_hc);
    else         exp_mc = sat(exp_mc);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    lat = 1;
    while (bus.cpu_ready !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("ready latency", 32'(lat), mem_access ? 32'd3 : 32'd1);
    chk("hit_count", 32'(hit_count), 32'(exp_hc));
    chk("miss_count", 32'(miss_count), 32'(exp_mc));
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    cpu_exp_t c;
    mem_exp_t m;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.flush = 1'b0;
    mem[16'h0010] = 8'h10;
    mem[16'h0110] = 8'h22;
    mem[16'h0030] = 8'h33;

    @(negedge clk);
    chk("rst cpu_ready", 32'(bus.cpu_ready), 32'd0);
    chk("rst cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
    chk("rst cpu_hit", 32'(bus.cpu_hit), 32'd0);
    chk("rst mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst hit_count", 32'(hit_count), 32'd0);
    chk("rst miss_count", 32'(miss_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // cold miss, then hit
    do_req(1'b0, 16'h0010, 8'h00, 1'b0, 8'h10, 1'b0);
    do_req(1'b0, 16'h0010, 8'h00, 1'b1, 8'h10, 1'b0);
    // index-0 conflict: 0x0110 evicts 0x0010 and vice versa
    do_req(1'b0, 16'h0110, 8'h00, 1'b0, 8'h22, 1'b0);
    do_req(1'b0, 16'h0010, 8'h00, 1'b0, 8'h10, 1'b0);
    do_req(1'b0, 16'h0110, 8'h00, 1'b0, 8'h22, 1'b0);
    // write hit updates the line; write miss does not allocate
    do_req(1'b0, 16'h0010, 8'h00, 1'b0, 8'h10, 1'b0);
    do_req(1'b1, 16'h0010, 8'hA5, 1'b1, 8'h00, 1'b0);
    do_req(1'b0, 16'h0010, 8'h00, 1'b1, 8'hA5, 1'b0);
    do_req(1'b1, 16'h0005, 8'h5A, 1'b0, 8'h00, 1'b0);
    do_req(1'b0, 16'h0005, 8'h00, 1'b0, 8'h5A, 1'b0);
    // flush together with a request: flush first, then the request misses
    do_req(1'b0, 16'h0010, 8'h00, 1'b0, 8'hA5, 1'b1);

    // reset during FILL
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0030;
    c.hit = 1'b0; c.rdata = 8'h33; c.chk_rd = 1'b1;
    cpu_q.push_back(c);
    m.we = 1'b0; m.addr = 16'h0030; m.wdata = '0;
    mem_q.push_back(m);
    @(posedge clk);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mem_req falls with rst", 32'(bus.mem_req), 32'd0);
    chk("rst mid-op miss_count", 32'(miss_count), 32'd0);
    cpu_q.delete();
    exp_hc = 0; exp_mc = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_req(1'b0, 16'h0030, 8'h00, 1'b0, 8'h33, 1'b0);

    // hit counter saturates at 3
    for (int i = 0; i < 5; i++) do_req(1'b0, 16'h0030, 8'h00, 1'b1, 8'h33, 1'b0);

    chk("cpu queue drained", 32'(cpu_q.size()), 32'd0);
    chk("mem queue drained", 32'(mem_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
